spi_byte_xfer: RTL and testbench
================================

Name: spi_byte_xfer

Overview:
SPI mode-0 master byte engine for the flash controller. It generates SCLK internally from clk_in using a half-period tick counter. It shifts one byte out on MOSI, MSB first, and captures one byte from MISO at the same time. The APB-side command sequencer drives it through a start/busy/done handshake, and cs_hold lets several bytes share one chip-select window (opcode, address, data).

Parameters:
DIV, 4, clk_in cycles per SCLK period; must be even and >= 2 (elaboration error otherwise); half-period H = DIV/2.

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  transfer request; accepted only in IDLE
tx_data  input  8  byte to send; latched on accept
cs_hold  input  1  latched on accept; 1 keeps cs_n low after this byte
miso  input  1  serial data from flash
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at byte completion
rx_data  output  8  captured byte; valid from done onward
sclk  output  1  SPI clock, idle low
cs_n  output  1  chip select, active low
mosi  output  1  serial data to flash

Behaviour:
- Reset (rst=0, any time, including mid-transfer): state IDLE, busy=0, done=0, rx_data=8'h00, sclk=0, cs_n=1, mosi=0, counters=0. This takes effect immediately; the partial byte is discarded.
- States: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
- IDLE: start=1 at a clk_in edge is accepted.
  - Latch tx_data and cs_hold.
  - Next cycle: busy=1, cs_n=0, mosi=tx_data[7], state SETUP.
  - A start while not IDLE is ignored (no queuing).
- SETUP: lasts H cycles with sclk=0 (CS setup time), then SHIFT.
- SHIFT: 16 half-periods of H cycles each; sclk toggles at the end of each half-period, starting with a rise.
  - Rising edge (sclk 0->1): sample miso into the shift register LSB, shifting left.
  - Falling edge (sclk 1->0): drive the next tx bit on mosi. No mosi change after the 8th falling edge.
  - After the 16th half-period, sclk=0 and the state is DONE.
- DONE (one cycle):
  - done=1, busy=0, rx_data=captured byte.
  - cs_n=1 if the latched cs_hold=0; stays 0 if cs_hold=1.
  - mosi=0.
  - Next state IDLE.
- busy duration: exactly 17*H cycles per byte (DIV=4: 34; DIV=2: 17). done follows in the next cycle.
- Start-to-done latency: 17*H+1 cycles from the accepting edge.
- Held CS: in IDLE with cs_n=0, a new start begins the SETUP phase without cs_n toggling. cs_n deasserts only at a DONE whose latched cs_hold=0.
- start asserted in the same cycle as done: not accepted. The engine is in DONE, not IDLE. Earliest accept is the next cycle.
- rx_data holds its value until the next DONE or reset.
- Half-period counter width: $clog2(H)+1 bits; it wraps to 0 at H-1.
- Bit counter: 4 bits, counts the 16 half-periods; no overflow beyond 15.

Decomposition:
- Package spi_pkg:
  - State enum: IDLE, SETUP, SHIFT, DONE.
  - Constant SPI_BITS=8.
  - Function half_period(DIV).
- One natural sub-module, sclk_tick_gen:
  - Parameter DIV.
  - Inputs clk_in, rst, run.
  - Outputs rise_tick and fall_tick (one-cycle pulses) and sclk.
  - The engine FSM owns the shift registers, CS, and handshake.

Test Plan:
- DIV=4, miso looped to mosi, start with tx_data=8'hA5, cs_hold=0 -> busy high for 34 cycles, done single pulse, rx_data=8'hA5, cs_n low 34 cycles then high with done, 8 sclk rising edges.
- DIV=4, slave model drives 8'h3C MSB-first (changing on sclk falling edges), tx_data=8'hFF -> rx_data=8'h3C; mosi stays 1 during SHIFT.
- DIV=4, sequence 8'h9F with cs_hold=1 then 8'h00 with cs_hold=0 -> cs_n stays low continuously across both bytes and returns to 1 only at the second done; two done pulses.
- DIV=4, start held high for 40 cycles -> exactly one transfer during busy; the second transfer is accepted only on the first cycle after done.
- DIV=4, rst pulled low at cycle 20 of a transfer -> same cycle: cs_n=1, sclk=0, busy=0, rx_data=8'h00; no done pulse. After release, a new transfer of 8'h5A completes normally.
- DIV=2, loopback 8'hC3 -> busy 17 cycles, sclk toggles every clk_in cycle after SETUP, rx_data=8'hC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte engine.
//   spi_state_e : engine FSM states
//   SPI_BITS    : bits per transfer
//   half_period : clk_in cycles per SCLK half-period for a given divider
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

  localparam int unsigned SPI_BITS         = 8;
  localparam int unsigned SPI_HALF_PERIODS = 2 * SPI_BITS;
  localparam int unsigned BIT_CNT_W        = 4;

  function automatic int unsigned half_period(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK generator: divides clk_in into half-periods of DIV/2 cycles while run=1.
// The first half-period after run rises is a silent low interval (CS setup);
// it ends with a fall_tick but sclk stays low. After that, sclk toggles at the
// end of every half-period, starting with a rise.
//   clk_in, rst : clock, async active-low reset
//   run         : 1 while the engine is in SETUP or SHIFT
//   rise_tick   : strobe, sclk goes 0->1 at the coming clk_in edge
//   fall_tick   : strobe, half-period ending with sclk going (or staying) low
//   sclk        : registered SPI clock, idle low
module sclk_tick_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic run,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int unsigned H  = half_period(DIV);
  localparam int unsigned CW = $clog2(H) + 1;

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("sclk_tick_gen: DIV must be even and >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;     // logical phase; 1 = high half (or setup) in progress
  logic          sclk_q, sclk_d;
  logic          wrap;

  // Half-period counter and phase tracking
  always_comb begin
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    sclk_d = sclk_q;
    wrap   = run && (cnt_q == CW'(H - 1));
    if (!run) begin
      cnt_d  = '0;
      ph_d   = 1'b1;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      ph_d   = ~ph_q;
      sclk_d = ~ph_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      ph_q   <= 1'b1;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      sclk_q <= sclk_d;
    end
  end

  assign rise_tick = wrap && !ph_q;
  assign fall_tick = wrap && ph_q;
  assign sclk      = sclk_q;

endmodule

// File: rtl/spi_byte_xfer.sv
// SPI mode-0 master byte engine. Shifts one byte out on mosi (MSB first) while
// capturing one byte from miso, with a start/busy/done handshake. cs_hold keeps
// cs_n asserted after the byte so several bytes share one chip-select window.
//   clk_in, rst  : clock, async active-low reset
//   start        : transfer request, accepted in IDLE only
//   tx_data      : byte to send, latched on accept
//   cs_hold      : latched on accept; 1 keeps cs_n low after this byte
//   miso         : serial data from flash
//   busy         : transfer in progress
//   done         : one-cycle pulse at byte completion
//   rx_data      : captured byte, held until next completion
//   sclk, cs_n, mosi : SPI bus
module spi_byte_xfer
  import spi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                cs_hold,
  input  logic                miso,
  output logic                busy,
  output logic                done,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                sclk,
  output logic                cs_n,
  output logic                mosi
);

  localparam logic [BIT_CNT_W-1:0] LAST_HALF = BIT_CNT_W'(SPI_HALF_PERIODS - 1);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("spi_byte_xfer: DIV must be even and >= 2");
  end

  spi_state_e            state_q, state_d;
  logic [SPI_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [SPI_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [SPI_BITS-1:0]   rx_data_q, rx_data_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;

  logic run;
  logic rise_tick;
  logic fall_tick;

  assign run = (state_q == SETUP) || (state_q == SHIFT);

  sclk_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  // Engine next-state and output logic
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          hold_d    = cs_hold;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          mosi_d    = tx_data[SPI_BITS-1];
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end

      // The tick generator's silent first half-period is the CS setup time
      SETUP: begin
        if (fall_tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (rise_tick) begin
          rx_sr_d   = {rx_sr_q[SPI_BITS-2:0], miso};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end else if (fall_tick) begin
          if (bit_cnt_q == LAST_HALF) begin
            state_d   = DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            rx_data_d = rx_sr_q;
            cs_n_d    = ~hold_q;
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
          end else begin
            mosi_d    = tx_sr_q[SPI_BITS-2];
            tx_sr_d   = {tx_sr_q[SPI_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_byte_xfer.sv
// Bench for spi_byte_xfer: one instance with DIV=4 (index 0), one with DIV=2
// (index 1). A slave model drives miso either looped from mosi or from a byte
// shifted out MSB first on sclk falling edges.
module tb_spi_byte_xfer;

  logic       clk;
  logic       rst_a     [2];
  logic       start_a   [2];
  logic [7:0] tx_a      [2];
  logic       hold_a    [2];
  logic       busy_a    [2];
  logic       done_a    [2];
  logic [7:0] rx_a      [2];
  logic       sclk_a    [2];
  logic       cs_n_a    [2];
  logic       mosi_a    [2];
  logic       loop_a    [2];
  logic       slv_bit   [2];
  logic       miso0, miso1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic        cs_low_m [2];   // model: cs_n expected low while idle

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso0 = loop_a[0] ? mosi_a[0] : slv_bit[0];
  assign miso1 = loop_a[1] ? mosi_a[1] : slv_bit[1];

  spi_byte_xfer #(.DIV(4)) u_div4 (
    .clk_in (clk),        .rst     (rst_a[0]),  .start   (start_a[0]),
    .tx_data(tx_a[0]),    .cs_hold (hold_a[0]), .miso    (miso0),
    .busy   (busy_a[0]),  .done    (done_a[0]), .rx_data (rx_a[0]),
    .sclk   (sclk_a[0]),  .cs_n    (cs_n_a[0]), .mosi    (mosi_a[0])
  );

  spi_byte_xfer #(.DIV(2)) u_div2 (
    .clk_in (clk),        .rst     (rst_a[1]),  .start   (start_a[1]),
    .tx_data(tx_a[1]),    .cs_hold (hold_a[1]), .miso    (miso1),
    .busy   (busy_a[1]),  .done    (done_a[1]), .rx_data (rx_a[1]),
    .sclk   (sclk_a[1]),  .cs_n    (cs_n_a[1]), .mosi    (mosi_a[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete byte transfer on instance d, checked against the model.
  task automatic run_xfer(input int d, input logic [7:0] tx, input logic hold,
                          input logic loop, input logic [7:0] sbyte);
    int unsigned h = (d == 0) ? 2 : 1;
    int busy_cnt = 0, rises = 0, falls = 0, mosi_err = 0, cs_err = 0;
    logic prev_sclk = 1'b0;
    logic seen_done = 1'b0;
    logic [7:0] exp_rx = loop ? tx : sbyte;
    int k;
    @(negedge clk);
    check($sformatf("idle_cs_n[%0d]", d), 32'(cs_n_a[d]), 32'(!cs_low_m[d]));
    loop_a[d]  = loop;
    slv_bit[d] = sbyte[7];
    tx_a[d]    = tx;
    hold_a[d]  = hold;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c != 0) @(negedge clk);
      if (sclk_a[d] && !prev_sclk) rises++;
      if (!sclk_a[d] && prev_sclk) begin
        falls++;
        if (falls < 8) slv_bit[d] = sbyte[7 - falls];
      end
      prev_sclk = sclk_a[d];
      if (done_a[d]) begin
        seen_done = 1'b1;
        break;
      end
      if (busy_a[d]) begin
        busy_cnt++;
        if (cs_n_a[d] !== 1'b0) cs_err++;
        k = (falls > 7) ? 7 : falls;
        if (mosi_a[d] !== tx[7 - k]) mosi_err++;
      end
    end
    check($sformatf("done_seen[%0d]", d), 32'(seen_done), 32'd1);
    check($sformatf("busy_len[%0d]", d), 32'(busy_cnt), 32'(17 * h));
    check($sformatf("sclk_rises[%0d]", d), 32'(rises), 32'd8);
    check($sformatf("sclk_falls[%0d]", d), 32'(falls), 32'd8);
    check($sformatf("mosi_bits[%0d]", d), 32'(mosi_err), 32'd0);
    check($sformatf("cs_low_busy[%0d]", d), 32'(cs_err), 32'd0);
    check($sformatf("rx_data[%0d]", d), 32'(rx_a[d]), 32'(exp_rx));
    check($sformatf("done_cs_n[%0d]", d), 32'(cs_n_a[d]), 32'(!hold));
    check($sformatf("done_busy[%0d]", d), 32'(busy_a[d]), 32'd0);
    check($sformatf("done_mosi[%0d]", d), 32'(mosi_a[d]), 32'd0);
    @(negedge clk);
    check($sformatf("done_pulse[%0d]", d), 32'(done_a[d]), 32'd0);
    check($sformatf("rx_hold[%0d]", d), 32'(rx_a[d]), 32'(exp_rx));
    cs_low_m[d] = hold;
  endtask

  initial begin
    int ph, run1, gap;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b0; start_a[d] = 1'b0; tx_a[d] = 8'h00; hold_a[d] = 1'b0;
      loop_a[d] = 1'b1; slv_bit[d] = 1'b0; cs_low_m[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy[%0d]", d), 32'(busy_a[d]), 32'd0);
      check($sformatf("rst_done[%0d]", d), 32'(done_a[d]), 32'd0);
      check($sformatf("rst_rx[%0d]", d),   32'(rx_a[d]),   32'd0);
      check($sformatf("rst_sclk[%0d]", d), 32'(sclk_a[d]), 32'd0);
      check($sformatf("rst_cs_n[%0d]", d), 32'(cs_n_a[d]), 32'd1);
      check($sformatf("rst_mosi[%0d]", d), 32'(mosi_a[d]), 32'd0);
      rst_a[d] = 1'b1;
    end

    // Directed cases
    run_xfer(0, 8'hA5, 1'b0, 1'b1, 8'h00);
    run_xfer(0, 8'hFF, 1'b0, 1'b0, 8'h3C);
    run_xfer(0, 8'h9F, 1'b1, 1'b0, 8'hC2);
    run_xfer(0, 8'h00, 1'b0, 1'b0, 8'h17);
    run_xfer(1, 8'hC3, 1'b0, 1'b1, 8'h00);

    // start held high: one transfer, next accepted right after done
    @(negedge clk);
    loop_a[0] = 1'b1; tx_a[0] = 8'h81; hold_a[0] = 1'b0; start_a[0] = 1'b1;
    ph = 0; run1 = 0; gap = 0;
    for (int c = 0; c < 200 && ph < 3; c++) begin
      @(negedge clk);
      case (ph)
        0: if (busy_a[0]) run1++; else if (run1 > 0) begin ph = 1; gap = 1; end
        1: if (busy_a[0]) begin ph = 2; start_a[0] = 1'b0; end else gap++;
        default: if (done_a[0]) ph = 3;
      endcase
    end
    check("held_first_busy", 32'(run1), 32'd34);
    check("held_gap", 32'(gap), 32'd2);
    check("held_second_done", 32'(ph), 32'd3);
    check("held_rx", 32'(rx_a[0]), 32'h81);
    start_a[0] = 1'b0;
    cs_low_m[0] = 1'b0;
    @(negedge clk);

    // Reset in the middle of a transfer
    @(negedge clk);
    loop_a[0] = 1'b1; tx_a[0] = 8'hE7; hold_a[0] = 1'b1; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst_a[0] = 1'b0;
    #1;
    check("midrst_cs_n", 32'(cs_n_a[0]), 32'd1);
    check("midrst_sclk", 32'(sclk_a[0]), 32'd0);
    check("midrst_busy", 32'(busy_a[0]), 32'd0);
    check("midrst_rx",   32'(rx_a[0]),   32'd0);
    check("midrst_done", 32'(done_a[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_a[0] = 1'b1;
    cs_low_m[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_no_done", 32'(done_a[0]), 32'd0);
    end
    run_xfer(0, 8'h5A, 1'b0, 1'b1, 8'h00);

    // Randomized transfers on both instances
    for (int i = 0; i < 16; i++) begin
      int d = int'($urandom_range(1, 0));
      logic [7:0] tx = 8'($urandom);
      logic [7:0] sb = 8'($urandom);
      logic hold = 1'($urandom);
      logic loop = 1'($urandom);
      run_xfer(d, tx, hold, loop, sb);
    end
    run_xfer(0, 8'h3E, 1'b0, 1'b0, 8'hD4);
    run_xfer(1, 8'h61, 1'b0, 1'b0, 8'h2B);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
